// File: rtl/neuron_sequencer_pkg.sv
// Shared types and width helpers for the neuron sequencer and its bench.
package neuron_sequencer_pkg;

  localparam int DEFAULT_NUM_WEIGHTS = 4;

  // Guards against zero-width vectors when a dimension is 1.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TYPE_W = clog2_min1(DEFAULT_NUM_WEIGHTS);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    INTEGRATE,
    WRITE,
    DONE
  } seq_state_e;

endpackage

// File: rtl/neuron_sequencer_axon_scan_counter.sv
// Axon index counter for the integrate phase; saturates at the last axon.
module neuron_sequencer_axon_scan_counter
  import neuron_sequencer_pkg::*;
#(
  parameter int NUM_AXONS = 256,
  parameter int AW        = clog2_min1(NUM_AXONS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          en_i,
  output logic [AW-1:0] idx_nxt_o,
  output logic          last_o
);

  localparam logic [AW-1:0] IDX_LAST = AW'(NUM_AXONS - 1);

  logic [AW-1:0] idx_q, idx_d;

  assign last_o = (idx_q == IDX_LAST);

  // The next index is exported so registered datapath controls line up with it.
  always_comb begin
    idx_d = idx_q;
    if (start_i) begin
      idx_d = '0;
    end else if (en_i && !last_o) begin
      idx_d = idx_q + AW'(1);
    end
  end

  assign idx_nxt_o = idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/neuron_sequencer.sv
// Per-timestep neuron walk: fetch row, load, integrate each axon, write back.
module neuron_sequencer
  import neuron_sequencer_pkg::*;
#(
  parameter int NUM_AXONS       = 256,
  parameter int NUM_NEURONS     = 256,
  parameter int NUM_WEIGHTS     = 4,
  parameter int POTENTIAL_WIDTH = 9
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          tick,
  input  logic [NUM_AXONS-1:0]                          axon_spikes,
  input  logic [clog2_min1(NUM_WEIGHTS)*NUM_AXONS-1:0]  axon_types,
  output logic [clog2_min1(NUM_NEURONS)-1:0]            csram_addr,
  input  logic [NUM_AXONS-1:0]                          synapses,
  output logic                                          next_neuron,
  output logic                                          integrator_reg_en,
  output logic                                          write_current_potential,
  output logic [clog2_min1(NUM_WEIGHTS)-1:0]            neuron_instruction,
  input  logic [POTENTIAL_WIDTH-1:0]                    potential_in,
  input  logic                                          spike_in,
  output logic                                          potential_wr_en,
  output logic [POTENTIAL_WIDTH-1:0]                    potential_wr_data,
  output logic                                          spike_valid,
  output logic [clog2_min1(NUM_NEURONS)-1:0]            spike_neuron,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          tick_overrun
);

  localparam int AW = clog2_min1(NUM_AXONS);
  localparam int NW = clog2_min1(NUM_NEURONS);
  localparam int TW = clog2_min1(NUM_WEIGHTS);
  localparam logic [NW-1:0] N_LAST = NW'(NUM_NEURONS - 1);

  seq_state_e            state_q, state_d;
  logic [NW-1:0]         n_q, n_d;
  logic [NUM_AXONS-1:0]  spikes_q, spikes_d;
  logic                  overrun_q, overrun_d;
  logic                  next_neuron_q, next_neuron_d;
  logic                  reg_en_q, reg_en_d;
  logic                  wcp_q, wcp_d;
  logic [TW-1:0]         instr_q, instr_d;
  logic                  wr_en_q, wr_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  cnt_start, cnt_en, cnt_last;
  logic [AW-1:0]         axon_sel;

  neuron_sequencer_axon_scan_counter #(
    .NUM_AXONS (NUM_AXONS),
    .AW        (AW)
  ) u_axon_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (cnt_start),
    .en_i      (cnt_en),
    .idx_nxt_o (axon_sel),
    .last_o    (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    spikes_d  = spikes_q;
    overrun_d = overrun_q | (tick && (state_q != IDLE));
    cnt_start = 1'b0;
    cnt_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d  = FETCH;
          n_d      = '0;
          spikes_d = axon_spikes;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        state_d   = INTEGRATE;
        cnt_start = 1'b1;
      end
      INTEGRATE: begin
        cnt_en = 1'b1;
        if (cnt_last) state_d = WRITE;
      end
      WRITE: begin
        if (n_q == N_LAST) begin
          state_d = DONE;
        end else begin
          n_d     = n_q + NW'(1);
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Controls are registered, so they are decoded from the state being entered.
    next_neuron_d = (state_d == LOAD);
    wcp_d         = (state_d == LOAD);
    reg_en_d      = (state_d == LOAD) ||
                    ((state_d == INTEGRATE) && spikes_q[axon_sel] && synapses[axon_sel]);
    instr_d       = (state_d == INTEGRATE) ? axon_types[int'(axon_sel)*TW +: TW] : instr_q;
    wr_en_d       = (state_d == WRITE);
    busy_d        = (state_d != IDLE) && (state_d != DONE);
    done_d        = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      n_q           <= '0;
      spikes_q      <= '0;
      overrun_q     <= 1'b0;
      next_neuron_q <= 1'b0;
      reg_en_q      <= 1'b0;
      wcp_q         <= 1'b0;
      instr_q       <= '0;
      wr_en_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      spikes_q      <= spikes_d;
      overrun_q     <= overrun_d;
      next_neuron_q <= next_neuron_d;
      reg_en_q      <= reg_en_d;
      wcp_q         <= wcp_d;
      instr_q       <= instr_d;
      wr_en_q       <= wr_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign csram_addr              = n_q;
  assign spike_neuron            = n_q;
  assign next_neuron             = next_neuron_q;
  assign integrator_reg_en       = reg_en_q;
  assign write_current_potential = wcp_q;
  assign neuron_instruction      = instr_q;
  assign potential_wr_en         = wr_en_q;
  // The datapath result settles only once the last integrate edge has passed,
  // so data and spike are qualified by the registered write strobe.
  assign potential_wr_data       = wr_en_q ? potential_in : '0;
  assign spike_valid             = wr_en_q & spike_in;
  assign busy                    = busy_q;
  assign done                    = done_q;
  assign tick_overrun            = overrun_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed bench: 4-axon, 2-neuron core with a small CSRAM and LIF datapath model.
module tb_neuron_sequencer;
  import neuron_sequencer_pkg::*;

  localparam int NA   = 4;
  localparam int NN   = 2;
  localparam int PW   = 9;
  localparam int MAXC = 24;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 tick = 1'b0;
  logic [NA-1:0]        axon_spikes = '0;
  logic [TYPE_W*NA-1:0] axon_types = 8'hE4;
  logic                 csram_addr;
  logic [NA-1:0]        synapses;
  logic                 next_neuron, integrator_reg_en, write_current_potential;
  logic [TYPE_W-1:0]    neuron_instruction;
  logic [PW-1:0]        potential_in;
  logic                 spike_in;
  logic                 potential_wr_en;
  logic [PW-1:0]        potential_wr_data;
  logic                 spike_valid, spike_neuron, busy, done, tick_overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neuron_sequencer #(
    .NUM_AXONS(NA), .NUM_NEURONS(NN), .NUM_WEIGHTS(4), .POTENTIAL_WIDTH(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .axon_spikes(axon_spikes),
    .axon_types(axon_types), .csram_addr(csram_addr), .synapses(synapses),
    .next_neuron(next_neuron), .integrator_reg_en(integrator_reg_en),
    .write_current_potential(write_current_potential),
    .neuron_instruction(neuron_instruction), .potential_in(potential_in),
    .spike_in(spike_in), .potential_wr_en(potential_wr_en),
    .potential_wr_data(potential_wr_data), .spike_valid(spike_valid),
    .spike_neuron(spike_neuron), .busy(busy), .done(done), .tick_overrun(tick_overrun)
  );

  // CSRAM and datapath model: weights 3,5,7,-2; leak 1; threshold 20 resets to 0.
  logic [NA-1:0] mem_syn [NN];
  logic [PW-1:0] mem_pot [NN];
  logic [PW-1:0] init_pot [NN];
  logic          load_req = 1'b0;
  logic [PW-1:0] integ = '0;

  function automatic logic [PW-1:0] wt(input logic [TYPE_W-1:0] t);
    case (t)
      2'd0:    return 9'd3;
      2'd1:    return 9'd5;
      2'd2:    return 9'd7;
      default: return 9'h1FE;
    endcase
  endfunction

  always @(posedge clk) begin
    synapses <= mem_syn[csram_addr];
    if (load_req) mem_pot <= init_pot;
    else if (potential_wr_en) mem_pot[csram_addr] <= potential_wr_data;
    if (integrator_reg_en)
      integ <= next_neuron ? mem_pot[csram_addr]
                           : integ + (write_current_potential ? 9'd0 : wt(neuron_instruction));
  end

  assign spike_in     = ($signed(integ) >= $signed(9'sd20));
  assign potential_in = spike_in ? 9'd0 : integ - 9'd1;

  logic [31:0]       en_tr, wr_tr, busy_tr, spk_tr;
  int                done_cyc, wr_cnt, spk_cnt;
  logic [PW-1:0]     wr_data_l [4];
  logic              wr_addr_l [4];
  logic              spk_n_l;
  logic [TYPE_W-1:0] instr_l [32];
  logic [20:0]       rst_snap;

  task automatic setup(input logic [NA-1:0] spk, input logic [NA-1:0] row0,
                       input logic [NA-1:0] row1, input logic [PW-1:0] p0,
                       input logic [PW-1:0] p1);
    @(negedge clk);
    axon_spikes = spk;
    mem_syn[0]  = row0;
    mem_syn[1]  = row1;
    init_pot[0] = p0;
    init_pot[1] = p1;
    load_req    = 1'b1;
    @(negedge clk);
    load_req    = 1'b0;
  endtask

  // Pulses tick, then samples every negedge for MAXC cycles; cycle c is c edges after the tick.
  task automatic run_ts(input int tick2, input int rst_cyc);
    en_tr = '0; wr_tr = '0; busy_tr = '0; spk_tr = '0;
    done_cyc = 0; wr_cnt = 0; spk_cnt = 0; spk_n_l = 1'b0; rst_snap = '1;
    for (int i = 0; i < 4; i++) begin wr_data_l[i] = 'x; wr_addr_l[i] = 1'bx; end
    @(negedge clk);
    tick = 1'b1;
    for (int c = 1; c < MAXC; c++) begin
      @(negedge clk);
      tick = (c == tick2);
      if (rst_cyc > 0 && c == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        rst_snap = {csram_addr, next_neuron, integrator_reg_en, write_current_potential,
                    neuron_instruction, potential_wr_en, potential_wr_data, spike_valid,
                    spike_neuron, busy, done, tick_overrun};
      end else if (rst_cyc > 0 && c == rst_cyc + 1) begin
        rst_n = 1'b1;
      end
      en_tr[c]   = integrator_reg_en;
      wr_tr[c]   = potential_wr_en;
      busy_tr[c] = busy;
      spk_tr[c]  = spike_valid;
      instr_l[c] = neuron_instruction;
      if (potential_wr_en) begin
        if (wr_cnt < 4) begin
          wr_data_l[wr_cnt] = potential_wr_data;
          wr_addr_l[wr_cnt] = csram_addr;
        end
        wr_cnt++;
      end
      if (spike_valid) begin spk_n_l = spike_neuron; spk_cnt++; end
      if (done && done_cyc == 0) done_cyc = c;
    end
  endtask

  task automatic test_reset();
    logic [20:0] snap;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    snap = {csram_addr, next_neuron, integrator_reg_en, write_current_potential,
            neuron_instruction, potential_wr_en, potential_wr_data, spike_valid,
            spike_neuron, busy, done, tick_overrun};
    checks++; if (snap !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", snap); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({busy, done, potential_wr_en, integrator_reg_en} !== 4'b0) begin
      errors++; $display("FAIL reset_idle: got %b expected 0000", {busy, done, potential_wr_en, integrator_reg_en}); end
  endtask

  task automatic test_full_sweep();
    setup(4'b1111, 4'b1111, 4'b1111, 9'd0, 9'd0);
    run_ts(0, 0);
    checks++; if (done_cyc !== 15) begin errors++; $display("FAIL full_done_cycle: got %0d expected 15", done_cyc); end
    checks++; if (en_tr !== 32'h3E7C) begin errors++; $display("FAIL full_reg_en_trace: got %h expected 3e7c", en_tr); end
    checks++; if (wr_tr !== 32'h4080) begin errors++; $display("FAIL full_wr_trace: got %h expected 4080", wr_tr); end
    checks++; if (wr_addr_l[0] !== 1'b0 || wr_addr_l[1] !== 1'b1) begin
      errors++; $display("FAIL full_wr_addr: got %b,%b expected 0,1", wr_addr_l[0], wr_addr_l[1]); end
    checks++; if (wr_data_l[0] !== 9'd12 || wr_data_l[1] !== 9'd12) begin
      errors++; $display("FAIL full_wr_data: got %0d,%0d expected 12,12", wr_data_l[0], wr_data_l[1]); end
    checks++; if (busy_tr !== 32'h7FFE) begin errors++; $display("FAIL full_busy_trace: got %h expected 7ffe", busy_tr); end
    checks++; if (spk_cnt !== 0) begin errors++; $display("FAIL full_no_spike: got %0d expected 0", spk_cnt); end
  endtask

  task automatic test_sparse();
    setup(4'b0101, 4'b0011, 4'b0100, 9'd0, 9'd0);
    run_ts(0, 0);
    checks++; if (en_tr !== 32'h120C) begin errors++; $display("FAIL sparse_reg_en_trace: got %h expected 120c", en_tr); end
    for (int a = 0; a < NA; a++) begin
      checks++; if (instr_l[3+a] !== TYPE_W'(a) || instr_l[10+a] !== TYPE_W'(a)) begin
        errors++; $display("FAIL sparse_instr a=%0d: got %0d,%0d expected %0d", a, instr_l[3+a], instr_l[10+a], a); end
    end
    checks++; if (wr_data_l[0] !== 9'd2 || wr_data_l[1] !== 9'd6) begin
      errors++; $display("FAIL sparse_wr_data: got %0d,%0d expected 2,6", wr_data_l[0], wr_data_l[1]); end
    checks++; if (done_cyc !== 15) begin errors++; $display("FAIL sparse_done_cycle: got %0d expected 15", done_cyc); end
  endtask

  task automatic test_spike();
    setup(4'b0100, 4'b0000, 4'b0100, 9'd5, 9'd18);
    run_ts(0, 0);
    checks++; if (spk_cnt !== 1) begin errors++; $display("FAIL spike_count: got %0d expected 1", spk_cnt); end
    checks++; if (spk_tr !== 32'h4000) begin errors++; $display("FAIL spike_trace: got %h expected 4000", spk_tr); end
    checks++; if (spk_n_l !== 1'b1) begin errors++; $display("FAIL spike_neuron: got %b expected 1", spk_n_l); end
    checks++; if (wr_data_l[0] !== 9'd4 || wr_data_l[1] !== 9'd0) begin
      errors++; $display("FAIL spike_wr_data: got %0d,%0d expected 4,0", wr_data_l[0], wr_data_l[1]); end
  endtask

  task automatic test_no_spikes();
    setup(4'b0000, 4'b1111, 4'b1111, 9'd10, 9'd0);
    run_ts(0, 0);
    checks++; if (en_tr !== 32'h0204) begin errors++; $display("FAIL leak_reg_en_trace: got %h expected 0204", en_tr); end
    checks++; if (wr_data_l[0] !== 9'd9 || wr_data_l[1] !== 9'h1FF) begin
      errors++; $display("FAIL leak_wr_data: got %h,%h expected 009,1ff", wr_data_l[0], wr_data_l[1]); end
    checks++; if (done_cyc !== 15 || wr_tr !== 32'h4080) begin
      errors++; $display("FAIL leak_timing: got done %0d wr %h expected 15 4080", done_cyc, wr_tr); end
  endtask

  task automatic test_overrun();
    checks++; if (tick_overrun !== 1'b0) begin errors++; $display("FAIL overrun_initial: got %b expected 0", tick_overrun); end
    setup(4'b1111, 4'b1111, 4'b1111, 9'd0, 9'd0);
    run_ts(15, 0);
    checks++; if (done_cyc !== 15 || busy_tr !== 32'h7FFE) begin
      errors++; $display("FAIL overrun_tick_in_done: got done %0d busy %h expected 15 7ffe", done_cyc, busy_tr); end
    checks++; if (tick_overrun !== 1'b1) begin errors++; $display("FAIL overrun_done_flag: got %b expected 1", tick_overrun); end
    run_ts(5, 0);
    checks++; if (done_cyc !== 15 || wr_tr !== 32'h4080 || en_tr !== 32'h3E7C) begin
      errors++; $display("FAIL overrun_mid_ignored: got done %0d wr %h en %h expected 15 4080 3e7c", done_cyc, wr_tr, en_tr); end
    checks++; if (tick_overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", tick_overrun); end
    run_ts(0, 0);
    checks++; if (done_cyc !== 15 || wr_cnt !== 2 || tick_overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_next_ts: got done %0d wr %0d ovr %b expected 15 2 1", done_cyc, wr_cnt, tick_overrun); end
  endtask

  task automatic test_reset_mid();
    setup(4'b1111, 4'b1111, 4'b1111, 9'd0, 9'd0);
    run_ts(0, 11);
    checks++; if (rst_snap !== '0) begin errors++; $display("FAIL rstmid_outputs: got %h expected 0", rst_snap); end
    checks++; if (wr_tr !== 32'h0080) begin errors++; $display("FAIL rstmid_wr_trace: got %h expected 0080", wr_tr); end
    checks++; if (en_tr !== 32'h067C) begin errors++; $display("FAIL rstmid_reg_en_trace: got %h expected 067c", en_tr); end
    checks++; if (done_cyc !== 0 || tick_overrun !== 1'b0) begin
      errors++; $display("FAIL rstmid_done_ovr: got done %0d ovr %b expected 0 0", done_cyc, tick_overrun); end
    run_ts(0, 0);
    checks++; if (done_cyc !== 15 || en_tr !== 32'h3E7C) begin
      errors++; $display("FAIL rstmid_rerun: got done %0d en %h expected 15 3e7c", done_cyc, en_tr); end
    checks++; if (wr_cnt !== 2 || wr_addr_l[0] !== 1'b0 || wr_addr_l[1] !== 1'b1) begin
      errors++; $display("FAIL rstmid_rerun_wr: got %0d %b,%b expected 2 0,1", wr_cnt, wr_addr_l[0], wr_addr_l[1]); end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_sparse();
    test_spike();
    test_no_spikes();
    test_overrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
